// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bus: instruction memory read port, decode redirect and IF/ID handshake.
// The fetch queue is master; memory and decode sit on the slave side.
interface inst_fetch_queue_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: one outstanding read to a 1-cycle memory,
// {inst, pc} FIFO toward IF/ID, and flush/refetch on branch redirect.
module inst_fetch_queue #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic clk,
    input  logic rst,
    inst_fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [31:0]       inst_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];

    logic [CNT_W:0] occupancy;
    logic           issue, push, pop;

    // Slots already promised to the outstanding read count as used; a pop in
    // the same cycle is ignored so the credit check stays one comparator.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue     = !rst && !bus.redirect && (occupancy < (CNT_W+1)'(DEPTH));
    assign push      = inflight_q && !bus.redirect;
    assign pop       = (count_q != '0) && bus.inst_ready && !bus.redirect;

    assign bus.mem_req    = issue;
    assign bus.mem_addr   = fetch_pc_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = inst_q[head_q];
    assign bus.inst_pc    = pc_q[head_q];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;

        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero until first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            inst_q[tail_q] <= bus.mem_rdata;
            pc_q[tail_q]   <= inflight_pc_q;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: preloaded memory mem[i] = i + 0x100,
// reset, streaming, stall, redirect, back-to-back redirect, wrap and mid-run reset.
module tb_inst_fetch_queue;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;

    logic clk, rst;
    logic [31:0] mem [0:65535];
    int total, passed;

    inst_fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

    inst_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) if (bus.mem_req) bus.mem_rdata <= mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [ADDR_W-1:0] pc);
        chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
        chk({tag, "_pc"},    32'(bus.inst_pc),    32'(pc));
        chk({tag, "_inst"},  bus.inst,            32'(pc) + 32'h100);
    endtask

    // A response must never land in a full FIFO.
    always @(negedge clk)
        if (!rst && dut.inflight_q && !bus.redirect)
            chk("push_not_full", 32'(dut.count_q < (ADDR_W)'(DEPTH)), 32'd1);

    initial begin
        logic [ADDR_W-1:0] pc;
        total  = 0;
        passed = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'(i) + 32'h100;
        bus.mem_rdata   = '0;
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b1;

        cyc(); cyc(); #1;
        chk("rst_mem_req",  32'(bus.mem_req),    32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr),   32'd0);
        chk("rst_valid",    32'(bus.inst_valid), 32'd0);
        chk("rst_inst",     bus.inst,            32'd0);
        chk("rst_inst_pc",  32'(bus.inst_pc),    32'd0);

        // N: first cycle out of reset
        cyc(); rst = 1'b0; #1;
        chk("n_mem_req",  32'(bus.mem_req),    32'd1);
        chk("n_mem_addr", 32'(bus.mem_addr),   32'd0);
        chk("n_valid",    32'(bus.inst_valid), 32'd0);
        cyc(); #1;
        chk("n1_mem_addr", 32'(bus.mem_addr),   32'd1);
        chk("n1_valid",    32'(bus.inst_valid), 32'd0);
        cyc(); #1;
        chk_head("n2", 16'd0);

        // Stall N+3..N+12: fills to DEPTH then stops fetching
        for (int c = 0; c < 10; c++) begin
            cyc(); bus.inst_ready = 1'b0; #1;
            chk_head("stall", 16'd1);
        end
        chk("stall_mem_req", 32'(bus.mem_req), 32'd0);
        chk("stall_count",   32'(dut.count_q), 32'd4);

        // Release: pending pop not credited, then gapless stream
        for (int k = 0; k < 8; k++) begin
            cyc(); bus.inst_ready = 1'b1; #1;
            chk_head("release", 16'(1 + k));
            if (k == 0) chk("release_no_credit", 32'(bus.mem_req), 32'd0);
            if (k == 1) chk("release_reissue",   32'(bus.mem_req), 32'd1);
        end

        // Fill again, then one-cycle reset pulse
        for (int c = 0; c < 5; c++) begin
            cyc(); bus.inst_ready = 1'b0; #1;
        end
        chk("full_count", 32'(dut.count_q), 32'd4);
        cyc(); rst = 1'b1; bus.inst_ready = 1'b1; #1;
        chk("rstp_mem_req", 32'(bus.mem_req), 32'd0);
        cyc(); rst = 1'b0; #1;
        chk("rstp_valid",    32'(bus.inst_valid), 32'd0);
        chk("rstp_inst",     bus.inst,            32'd0);
        chk("rstp_inst_pc",  32'(bus.inst_pc),    32'd0);
        chk("rstp_mem_addr", 32'(bus.mem_addr),   32'd0);
        chk("rstp_mem_req",  32'(bus.mem_req),    32'd1);
        cyc(); #1;
        chk("rstp1_mem_addr", 32'(bus.mem_addr),   32'd1);
        chk("rstp1_valid",    32'(bus.inst_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 3) bus.inst_ready = 1'b0;
            #1;
            chk_head("restart", 16'(k));
        end

        // FIFO builds to PCs 3..5 with PC 6 in flight, then redirect to 7
        cyc(); #1;
        chk_head("pre_redir", 16'd3);
        cyc(); bus.redirect = 1'b1; bus.redirect_pc = 16'h0007; #1;
        chk("redir_count",   32'(dut.count_q),    32'd3);
        chk("redir_inflt",   32'(dut.inflight_q), 32'd1);
        chk("redir_mem_req", 32'(bus.mem_req),    32'd0);
        cyc(); bus.redirect = 1'b0; bus.inst_ready = 1'b1; #1;
        chk("r1_mem_addr", 32'(bus.mem_addr),   32'h7);
        chk("r1_mem_req",  32'(bus.mem_req),    32'd1);
        chk("r1_valid",    32'(bus.inst_valid), 32'd0);
        cyc(); #1;
        chk("r2_valid",    32'(bus.inst_valid), 32'd0);
        chk("r2_mem_addr", 32'(bus.mem_addr),   32'h8);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk_head("redir_out", 16'(7 + k));
        end

        // Redirect with inst_ready high, then a second redirect back-to-back
        cyc(); bus.redirect = 1'b1; bus.redirect_pc = 16'h0020; #1;
        chk_head("bb_head", 16'd10);
        chk("bb_mem_req", 32'(bus.mem_req), 32'd0);
        cyc(); bus.redirect_pc = 16'h0040; #1;
        chk("bb1_valid",    32'(bus.inst_valid), 32'd0);
        chk("bb1_mem_addr", 32'(bus.mem_addr),   32'h20);
        chk("bb1_mem_req",  32'(bus.mem_req),    32'd0);
        cyc(); bus.redirect = 1'b0; #1;
        chk("bb2_mem_addr", 32'(bus.mem_addr),   32'h40);
        chk("bb2_valid",    32'(bus.inst_valid), 32'd0);
        cyc(); #1;
        chk("bb3_valid", 32'(bus.inst_valid), 32'd0);
        cyc(); #1;
        chk_head("bb_out0", 16'h0040);
        cyc(); #1;
        chk_head("bb_out1", 16'h0041);

        // Wrap through the top of the address space
        cyc(); bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE; #1;
        cyc(); bus.redirect = 1'b0; #1;
        chk("wrap1_mem_addr", 32'(bus.mem_addr), 32'hFFFE);
        cyc(); #1;
        chk("wrap2_mem_addr", 32'(bus.mem_addr),   32'hFFFF);
        chk("wrap2_valid",    32'(bus.inst_valid), 32'd0);
        pc = 16'hFFFE;
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk_head("wrap_out", pc);
            if (k == 0) chk("wrap3_mem_addr", 32'(bus.mem_addr), 32'h0);
            pc = pc + 1'b1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end for the pipelined MIPS core. It reads the word-addressed instruction memory through a fixed one-cycle-latency synchronous read port and buffers fetched words with their PCs in a small FIFO. It presents them to the IF/ID stage under a valid/ready handshake and flushes on branch redirect from decode. It is the reading end of the instruction memory that the bench preloads.

## Interface

**Parameters**
- ADDR_W, 16, word-address width (65536-word instruction memory); PC counts words, +1 per instruction.
- DEPTH, 4, FIFO entries; power of two, ≥2.

**Ports**
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: one clock, synchronous, active-high.
- mem_req  out  1  read request to instruction memory this cycle.
- mem_addr  out  ADDR_W  word address; always equals internal fetch_pc.
- mem_rdata  in  32  read data, valid the cycle after a cycle with mem_req=1.
- redirect  in  1  taken branch/jump from decode; flush and refetch.
- redirect_pc  in  ADDR_W  target word address, sampled when redirect=1.
- inst_valid  out  1  FIFO head holds an instruction.
- inst  out  32  head instruction word.
- inst_pc  out  ADDR_W  word address of head instruction.
- inst_ready  in  1  IF/ID accepts head this cycle (0 = pipeline stall).

## Operation

- State: fetch_pc, FIFO of DEPTH {inst, pc} entries (head/tail pointers, count 0..DEPTH), inflight flag plus inflight_pc for the one outstanding read.
- Issue: mem_req = !rst && !redirect && (count + inflight) < DEPTH. Pending pop is not credited (conservative). On issue, fetch_pc <= fetch_pc + 1, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000). inflight <= 1 and inflight_pc <= fetch_pc.
- Response: in the cycle after an issue, mem_rdata is pushed at the tail with inflight_pc, unless redirect or rst is high that cycle, in which case it is discarded.
- Pop: when inst_valid && inst_ready && !redirect, the head advances.
- Simultaneous push and pop: both happen and count is unchanged. Push to a full FIFO cannot occur because of issue credit; the bench asserts this.
- Redirect, which has priority over push, pop and issue:
  - count <= 0 and pointers reset; the inflight response is dropped.
  - fetch_pc <= redirect_pc; mem_req = 0 in the redirect cycle.
  - Back-to-back redirects: the last one wins.
- inst_valid = (count != 0). inst and inst_pc are driven combinationally from the head entry. Values are don't-care while invalid, except 0 after reset.
- NOP (0x00000000) is an ordinary instruction with no special handling.

## Timing

- Reset values: mem_req=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0, count=0, inflight=0, fetch_pc=0.
- Reset mid-operation: same as above at the next edge; all buffered and inflight data is lost.
- Cycle N = first cycle with rst=0:
  - N: mem_req=1, mem_addr=0.
  - N+1: mem_addr=1, and mem[0] is pushed.
  - N+2: inst_valid=1, inst=mem[0], inst_pc=0.
  - Fetch-to-output latency is 2 cycles.
- Redirect asserted in cycle R: mem_req=0 in R; mem_addr=redirect_pc in R+1; target appears at the head in R+3. Instructions present in R never appear after R.
- Steady state with inst_ready=1: one instruction per cycle and no bubbles. count settles at 1 or 2.
- Stall with inst_ready=0: issue continues until count + inflight = DEPTH, then mem_req=0. On release, output is one per cycle with no gaps.

## Test plan

- Reset release with mem[i]=i+0x100 and inst_ready=1: consecutive cycles show inst_pc 0,1,2,3… with inst=0x100,0x101,… First valid at N+2, then no bubbles.
- Stall: hold inst_ready=0 for 10 cycles from N+3 -> count=4 and mem_req=0 after fill. On release the next 4 outputs are in-order PCs, followed by continuous stream.
- Redirect to 0x0007 while FIFO holds PCs 3..5 and a read is inflight -> PCs 3..6 never appear after redirect. mem_req=0 in R, mem_addr=7 in R+1, inst_pc=7 at R+3, then 8,9.
- Redirect and inst_ready=1 in the same cycle, plus back-to-back redirects to 0x0020 then 0x0040 -> no pop occurs, and the first output is inst_pc=0x0040.
- Wrap: redirect to 0xFFFE -> outputs inst_pc 0xFFFE, 0xFFFF, 0x0000, 0x0001 with matching mem words.
- rst pulsed for 1 cycle mid-stream with a full FIFO -> outputs are at reset values next cycle, and the stream restarts at pc 0 two cycles after rst falls.
